// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: word width, canonical NOP and fetch FSM states.
package rv32i_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction store: DEPTH x 32 words, one write port and one registered read port.
// A read and a write to the same word on the same edge returns the old contents.
module imem_array
   import rv32i_pkg::*;
#(
   parameter int unsigned     DEPTH   = 256,
   parameter int unsigned     AW      = $clog2(DEPTH),
   parameter logic [XLEN-1:0] RST_VAL = NOP_INSTR
) (
   input  logic            clk,
   input  logic            areset,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            re,
   input  logic            rclr,
   input  logic [AW-1:0]   raddr,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // rclr loads the reset word instead of the addressed entry.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rdata <= RST_VAL;
      end else if (re) begin
         rdata <= rclr ? RST_VAL : mem[raddr];
      end
   end

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction responder: accepts a PC, waits WAIT_STATES cycles, returns the word.
// Optional misaligned-fetch fault reporting is enabled by defining IMEM_MISALIGN_CHECK_EN.
module imem_fetch_responder #(
   parameter int unsigned                DEPTH       = 256,
   parameter int unsigned                AW          = $clog2(DEPTH),
   parameter int unsigned                WAIT_STATES = 2,
   parameter logic [rv32i_pkg::XLEN-1:0] NOP_INSTR   = rv32i_pkg::NOP_INSTR
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       fetch_req,
   input  logic [rv32i_pkg::XLEN-1:0] PC,
   output logic [rv32i_pkg::XLEN-1:0] Instr,
   output logic                       instr_valid,
   output logic                       load,
   output logic                       busy,
   output logic                       fault,
   input  logic                       prog_we,
   input  logic [AW-1:0]              prog_addr,
   input  logic [rv32i_pkg::XLEN-1:0] prog_data
);

   import rv32i_pkg::*;

   localparam int unsigned CW        = 4;
   localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

   fetch_state_e    state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] pc_q;

   logic [XLEN-1:0] rd_pc_c;
   logic            enter_done_c;
   logic            misalign_c;
   logic            unused_c;

   // With zero wait states the read happens on the accept edge, so it must use the live PC.
   always_comb begin
      rd_pc_c      = pc_q;
      enter_done_c = 1'b0;
      case (state)
         IDLE: begin
            rd_pc_c      = PC;
            enter_done_c = fetch_req && ZERO_WAIT;
         end
         WAIT:    enter_done_c = (cnt <= CW'(1));
         default: enter_done_c = 1'b0;
      endcase
   end

`ifdef IMEM_MISALIGN_CHECK_EN
   assign misalign_c = |rd_pc_c[1:0];
   assign unused_c   = ^rd_pc_c[XLEN-1:AW+2];
`else
   assign misalign_c = 1'b0;
   assign unused_c   = ^{rd_pc_c[XLEN-1:AW+2], rd_pc_c[1:0]};
`endif

   // Fetch sequencing plus the registered handshake outputs.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state       <= IDLE;
         cnt         <= '0;
         pc_q        <= '0;
         instr_valid <= 1'b0;
         load        <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         load        <= 1'b0;
         if (enter_done_c) begin
            instr_valid <= 1'b1;
            load        <= 1'b1;
            fault       <= misalign_c;
         end
         case (state)
            IDLE: begin
               if (fetch_req) begin
                  pc_q  <= PC;
                  cnt   <= CW'(WAIT_STATES);
                  busy  <= 1'b1;
                  state <= ZERO_WAIT ? DONE : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (enter_done_c) begin
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   imem_array #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .RST_VAL (NOP_INSTR)
   ) u_array (
      .clk    (clk),
      .areset (areset),
      .we     (prog_we),
      .waddr  (prog_addr),
      .wdata  (prog_data),
      .re     (enter_done_c),
      .rclr   (misalign_c),
      .raddr  (rd_pc_c[AW+1:2]),
      .rdata  (Instr)
   );

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder (default build or IMEM_MISALIGN_CHECK_EN).
module tb_imem_fetch_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 8;
   localparam int unsigned W     = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        areset;
   logic        fetch_req;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        instr_valid;
   logic        load;
   logic        busy;
   logic        fault;
   logic        prog_we;
   logic [AW-1:0] prog_addr;
   logic [31:0] prog_data;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] model [DEPTH];

   imem_fetch_responder #(
      .DEPTH       (DEPTH),
      .AW          (AW),
      .WAIT_STATES (W),
      .NOP_INSTR   (NOP)
   ) dut (
      .clk         (clk),
      .areset      (areset),
      .fetch_req   (fetch_req),
      .PC          (PC),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .load        (load),
      .busy        (busy),
      .fault       (fault),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data)
   );

   always #5 clk = ~clk;

   // Shadow of the instruction store: every accepted program write lands on the rising edge.
   always @(posedge clk) begin
      if (prog_we === 1'b1) model[prog_addr] <= prog_data;
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp_instr;
      logic        exp_fault;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_wr(input int n, input bit collide, input logic [AW-1:0] idx,
                           input logic [31:0] cdata, input bit rnd);
      if (collide && n == int'(W)) begin
         prog_we = 1'b1; prog_addr = idx; prog_data = cdata;
      end else if (rnd && $urandom_range(0, 2) == 0) begin
         prog_we = 1'b1; prog_addr = AW'($urandom); prog_data = $urandom;
      end else begin
         prog_we = 1'b0;
      end
   endtask

   // Expected result from the architectural rules, using the store contents just before the read edge.
   task automatic snap(input logic [31:0] pc, input bit use_exp, input logic [31:0] exp_i,
                       input bit exp_f, output logic [31:0] exp_w, output logic exp_fw);
      logic [AW-1:0] idx;
      idx = pc[AW+1:2];
      if (use_exp) begin
         exp_w = exp_i; exp_fw = exp_f;
      end else begin
         exp_w = model[idx]; exp_fw = 1'b0;
`ifdef IMEM_MISALIGN_CHECK_EN
         if (pc[1:0] != 2'b00) begin
            exp_w = NOP; exp_fw = 1'b1;
         end
`endif
      end
   endtask

   // One single-cycle request from IDLE; caller is positioned at a falling edge.
   task automatic run_fetch(input logic [31:0] pc, input bit use_exp, input logic [31:0] exp_i,
                            input bit exp_f, input bit collide, input logic [31:0] cdata,
                            input bit rnd, input string name);
      int got;
      logic [31:0] exp_w;
      logic exp_fw;
      got = 0;
      exp_w = '0; exp_fw = 1'b0;
      PC = pc; fetch_req = 1'b1;
      if (W == 0) snap(pc, use_exp, exp_i, exp_f, exp_w, exp_fw);
      drive_wr(0, collide, pc[AW+1:2], cdata, rnd);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            fetch_req = 1'b0;
            PC = $urandom;
            check({name, " busy"}, 32'(busy), 32'd1);
         end
         if (instr_valid) begin
            got = k;
            break;
         end
         if (k == int'(W)) snap(pc, use_exp, exp_i, exp_f, exp_w, exp_fw);
         drive_wr(k, collide, pc[AW+1:2], cdata, rnd);
      end
      prog_we = 1'b0;
      check({name, " latency"}, 32'(got), 32'(W + 1));
      check({name, " instr"}, Instr, exp_w);
      check({name, " fault"}, 32'(fault), 32'(exp_fw));
      check({name, " load"}, 32'(load), 32'd1);
      @(negedge clk);
      check({name, " pulse end"}, {29'd0, instr_valid, load, busy}, 32'd0);
   endtask

   vec_t vecs [8];

   initial begin
      logic [31:0] pc;
      int pulses, last;
      bit prev_load, seen;

      areset = 1'b1; fetch_req = 1'b0; PC = '0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (2) @(negedge clk);
      check("reset outputs", {27'd0, instr_valid, load, busy, fault, 1'b0}, 32'd0);
      check("reset instr", Instr, NOP);
      areset = 1'b0;

      for (int i = 0; i < int'(DEPTH); i++) begin
         prog_we = 1'b1; prog_addr = AW'(i); prog_data = $urandom;
         @(negedge clk);
      end
      begin
         logic [31:0] words [6];
         int          addrs [6];
         words = '{32'h0000_0297, 32'h0010_0113, 32'h0020_0193, 32'h4020_8233, 32'h0050_0093, 32'hFFF0_0313};
         addrs = '{0, 1, 2, 3, 4, 255};
         for (int i = 0; i < 6; i++) begin
            prog_we = 1'b1; prog_addr = AW'(addrs[i]); prog_data = words[i];
            @(negedge clk);
         end
      end
      prog_we = 1'b0;

      vecs[0] = '{32'h0000_0010, 32'h0050_0093, 1'b0};
      vecs[1] = '{32'h0000_0000, 32'h0000_0297, 1'b0};
      vecs[2] = '{32'h0000_0404, 32'h0010_0113, 1'b0};
      vecs[3] = '{32'h0000_03FC, 32'hFFF0_0313, 1'b0};
      vecs[4] = '{32'hFFFF_FC08, 32'h0020_0193, 1'b0};
`ifdef IMEM_MISALIGN_CHECK_EN
      vecs[5] = '{32'h0000_0006, NOP, 1'b1};
      vecs[6] = '{32'h0000_000D, NOP, 1'b1};
      vecs[7] = '{32'h0000_0007, NOP, 1'b1};
`else
      vecs[5] = '{32'h0000_0006, 32'h0010_0113, 1'b0};
      vecs[6] = '{32'h0000_000D, 32'h4020_8233, 1'b0};
      vecs[7] = '{32'h0000_0007, 32'h0010_0113, 1'b0};
`endif
      for (int i = 0; i < 8; i++) begin
         run_fetch(vecs[i].pc, 1'b1, vecs[i].exp_instr, vecs[i].exp_fault, 1'b0, '0, 1'b0,
                   $sformatf("vec%0d", i));
      end

      // Write to the word being read on the read edge: old data now, new data next time.
      run_fetch(32'h8, 1'b1, 32'h0020_0193, 1'b0, 1'b1, 32'hABCD_0123, 1'b0, "collide old");
      run_fetch(32'h8, 1'b1, 32'hABCD_0123, 1'b0, 1'b0, '0, 1'b0, "collide new");

      // Request held high: PC steps 0x0, 0x4, 0x8, garbage while busy.
      fetch_req = 1'b1; PC = 32'h0;
      pulses = 0; last = 0; prev_load = 1'b0;
      for (int k = 1; k <= 40 && pulses < 3; k++) begin
         @(negedge clk);
         check("b2b load single", 32'(load && prev_load), 32'd0);
         prev_load = load;
         if (instr_valid) begin
            check($sformatf("b2b instr%0d", pulses), Instr, model[pulses]);
            if (pulses > 0) check($sformatf("b2b gap%0d", pulses), 32'(k - last), 32'(W + 2));
            last = k;
            pulses++;
            if (pulses == 3) fetch_req = 1'b0;
            PC = 32'(pulses * 4);
         end else if (busy) begin
            PC = $urandom;
         end
      end
      check("b2b pulses", 32'(pulses), 32'd3);
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a fetch.
      fetch_req = 1'b1; PC = 32'h10;
      @(negedge clk);
      fetch_req = 1'b0;
      #2 areset = 1'b1;
      #1;
      check("async reset instr", Instr, NOP);
      check("async reset flags", {28'd0, instr_valid, load, busy, fault}, 32'd0);
      @(negedge clk);
      areset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < int'(W) + 3; k++) begin
         @(negedge clk);
         seen |= instr_valid;
      end
      check("abort no pulse", 32'(seen), 32'd0);
      run_fetch(32'h10, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, "after abort");

      // Random addresses and concurrent program writes against the shadow store.
      for (int i = 0; i < 40; i++) begin
         pc = $urandom;
         if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
         run_fetch(pc, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, $sformatf("rnd%0d", i));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
